chunked_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor: a WIDTH-bit operand pair is added CHUNK bits per clock through a narrow ripple datapath. It reports carry-out, signed overflow and zero. It sits beside the ALU wherever a wide add can tolerate latency in exchange for area, and talks to its neighbours through a valid/ready handshake on both sides.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 40 ++++
 rtl/chunked_adder.sv | 119 +++++++++++
 tb/tb_chunked_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
// Optional subtract path is enabled by defining ADDER_SUB_EN.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Counter width for a chunk index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry slice built from full_adder cells; also exposes
// the carry into its MSB so the top level can form signed overflow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic             cout,
   output logic [CHUNK-1:0] z,
   output logic             c_msb
);
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (z[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Define ADDER_SUB_EN to enable subtraction via the sub input.
module chunked_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDX_W  = idx_width(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready
   // are both high; ready/valid are decoded from the state register only.
   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_reg, b_reg, z_reg;
   logic             carry_reg, cout_reg, ovf_reg;

   logic [WIDTH-1:0] b_in;
   logic             c_in;

`ifdef ADDER_SUB_EN
   assign b_in = sub ? ~b : b;
   assign c_in = cin | sub;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_in       = b;
   assign c_in       = cin;
`endif

   logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
   logic             chunk_cout, chunk_cmsb;

   assign a_chunk = a_reg[int'(idx)*CHUNK +: CHUNK];
   assign b_chunk = b_reg[int'(idx)*CHUNK +: CHUNK];

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_chunk),
      .b     (b_chunk),
      .cin   (carry_reg),
      .cout  (chunk_cout),
      .z     (s_chunk),
      .c_msb (chunk_cmsb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         z_reg     <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b_in;
                  carry_reg <= c_in;
                  idx       <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               z_reg[int'(idx)*CHUNK +: CHUNK] <= s_chunk;
               carry_reg <= chunk_cout;
               if (idx == LAST_IDX) begin
                  cout_reg <= chunk_cout;
                  ovf_reg  <= chunk_cmsb ^ chunk_cout;
                  idx      <= '0;
                  state    <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign z         = z_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;
   assign zero      = (z_reg == '0);

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: three instances (CHUNK=4, 16, 1) share
// operands; each result is checked against hand-computed values.
module tb_chunked_adder;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   in_valid_v = '0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0, sub = 1'b0, out_ready = 1'b1;

   logic         in_ready_v[3], out_valid_v[3], cout_v[3], ovf_v[3], zero_v[3];
   logic [W-1:0] z_v[3];

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   chunked_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready),
      .z(z_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

   chunked_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready),
      .z(z_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

   chunked_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready),
      .z(z_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation on instance sel and check the result when it appears.
   task automatic run_op(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb, input logic [W-1:0] ez,
                         input logic ec, input logic eo, input int elat, input string tag);
      int lat;
      logic [W-1:0] zexp;
      a = av; b = bv; cin = ci; sub = sb;
      exp_q.push_back(ez);
      check({tag, "_in_ready"}, 32'(in_ready_v[sel]), 32'd1);
      in_valid_v[sel] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[sel] = 1'b0;
      lat = 0;
      while (out_valid_v[sel] !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_out_valid"}, 32'(out_valid_v[sel]), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(elat));
      zexp = exp_q.pop_front();
      check({tag, "_z"}, 32'(z_v[sel]), 32'(zexp));
      check({tag, "_cout"}, 32'(cout_v[sel]), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf_v[sel]), 32'(eo));
      check({tag, "_zero"}, 32'(zero_v[sel]), 32'(zexp == '0));
      if (out_ready) begin
         @(posedge clk); #1;
         check({tag, "_consumed"}, 32'(out_valid_v[sel]), 32'd0);
         check({tag, "_ready_again"}, 32'(in_ready_v[sel]), 32'd1);
      end
   endtask

   initial begin
      bit seen_valid;

      // Clock/reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
      check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("rst_z", 32'(z_v[0]), 32'd0);
      check("rst_cout", 32'(cout_v[0]), 32'd0);
      check("rst_ovf", 32'(ovf_v[0]), 32'd0);
      rst_n = 1'b1;

      // Basic adds on CHUNK=4
      run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "add_5555");
      run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "carry_all");
      run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "ovf_c4");
      run_op(0, 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 4, "cin_add");
      run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4, "neg_ovf");

      // Same overflow case on the single-chunk and bit-serial builds
      run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, "ovf_c16");
      run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16, "ovf_c1");

      // Subtract request
`ifdef ADDER_SUB_EN
      run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "sub_5_7");
      run_op(2, 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16, "sub_c1");
`else
      run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 4, "sub_ignored");
      run_op(2, 16'h0009, 16'h0004, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0, 16, "sub_ign_c1");
`endif

      // Backpressure: result held while new operands are offered and dropped
      out_ready = 1'b0;
      run_op(0, 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, 4, "bp");
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid_v[0] = 1'b1;
         @(posedge clk); #1;
         check("bp_hold_valid", 32'(out_valid_v[0]), 32'd1);
         check("bp_hold_ready", 32'(in_ready_v[0]), 32'd0);
         check("bp_hold_z", 32'(z_v[0]), 32'h0406);
      end
      in_valid_v[0] = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_consumed", 32'(out_valid_v[0]), 32'd0);
      check("bp_ready_again", 32'(in_ready_v[0]), 32'd1);

      // Reset during chunk 2 aborts the operation
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
      in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_z", 32'(z_v[0]), 32'd0);
      check("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid_v[0] === 1'b1) seen_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_valid", 32'(seen_valid), 32'd0);
      run_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 4, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
